// File: rtl/dbg_bridge_pkg.sv
// Shared definitions for the UART debug bridge: host command codes,
// reply codes, FSM state encoding and small elaboration-time helpers.
package dbg_bridge_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_PAYLOAD,
      ST_RD_SEND,
      ST_ACK,
      ST_NAK
   } state_t;

   function automatic int bytes_for(input int bits);
      return (bits + 7) / 8;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dbg_byte_shifter.sv
// Byte-lane register: loads one byte at a lane index, captures a whole word,
// or shifts right by one byte. out_o shows the next-state value.
module dbg_byte_shifter
   import dbg_bridge_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int IDX_W  = 1,
   parameter bit SERIAL = 1'b0,
   localparam int NB    = bytes_for(WIDTH),
   localparam int OW    = SERIAL ? 8 : WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [7:0]       byte_i,
   input  logic             capture_i,
   input  logic [WIDTH-1:0] cap_i,
   input  logic             shift_i,
   output logic [OW-1:0]    out_o
);

   logic [NB*8-1:0] data_q;
   logic [NB*8-1:0] data_d;
   logic [NB*8-1:0] cap_pad;

   always_comb begin
      cap_pad              = '0;
      cap_pad[WIDTH-1:0]   = cap_i;
   end

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] above;
      if (gi == NB - 1) begin : g_top
         assign above = 8'h00;
      end else begin : g_mid
         assign above = data_q[(gi+1)*8 +: 8];
      end
      assign data_d[gi*8 +: 8] = capture_i ? cap_pad[gi*8 +: 8] :
                                 shift_i   ? above :
                                 (load_i && idx_i == IDX_W'(gi)) ? byte_i :
                                 data_q[gi*8 +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   // Next-state view lets the owner commit a word in the same edge as its final byte.
   if (SERIAL) begin : g_serial
      assign out_o = data_d[7:0];
   end else begin : g_word
      assign out_o = data_d[WIDTH-1:0];
   end

endmodule

// File: rtl/uart_debug_bridge.sv
// Host command engine: 'W' writes the stimulus vector, 'R' reads the probe
// vector, 'S' pulses a DUT step; replies go out through a tx handshake.
module uart_debug_bridge
   import dbg_bridge_pkg::*;
#(
   parameter int IN_WIDTH       = 8,
   parameter int OUT_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 120000,
   parameter logic [IN_WIDTH-1:0] RESET_DRIVE = '0
) (
   input  logic                 iCE_CLK,
   input  logic                 rst_n,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic [IN_WIDTH-1:0]  drive_out,
   input  logic [OUT_WIDTH-1:0] probe_in,
   output logic                 dut_step,
   output logic                 busy,
   output logic                 overrun
);

   localparam int IN_BYTES  = bytes_for(IN_WIDTH);
   localparam int OUT_BYTES = bytes_for(OUT_WIDTH);
   localparam int IDX_W     = $clog2(max_int(IN_BYTES, OUT_BYTES) + 1);
   localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [IN_WIDTH-1:0] drive_q, drive_d;
   logic                tx_valid_q, tx_valid_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                step_q, step_d;
   logic                overrun_q, overrun_d;

   logic                wr_load;
   logic                rd_capture;
   logic                rd_shift;
   logic [IN_WIDTH-1:0] wr_word;
   logic [7:0]          rd_byte;
   logic                tx_fire;

   assign tx_fire = tx_valid_q && tx_ready;

   dbg_byte_shifter #(.WIDTH(IN_WIDTH), .IDX_W(IDX_W), .SERIAL(1'b0)) u_wr_shifter (
      .clk       (iCE_CLK),
      .rst_n     (rst_n),
      .load_i    (wr_load),
      .idx_i     (idx_q),
      .byte_i    (rx_data),
      .capture_i (1'b0),
      .cap_i     ('0),
      .shift_i   (1'b0),
      .out_o     (wr_word)
   );

   dbg_byte_shifter #(.WIDTH(OUT_WIDTH), .IDX_W(IDX_W), .SERIAL(1'b1)) u_rd_shifter (
      .clk       (iCE_CLK),
      .rst_n     (rst_n),
      .load_i    (1'b0),
      .idx_i     ('0),
      .byte_i    (8'h00),
      .capture_i (rd_capture),
      .cap_i     (probe_in),
      .shift_i   (rd_shift),
      .out_o     (rd_byte)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tmo_d      = tmo_q;
      drive_d    = drive_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      step_d     = 1'b0;
      overrun_d  = overrun_q;
      wr_load    = 1'b0;
      rd_capture = 1'b0;
      rd_shift   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               idx_d = '0;
               tmo_d = '0;
               case (rx_data)
                  CMD_WRITE: state_d = ST_WR_PAYLOAD;
                  CMD_READ: begin
                     rd_capture = 1'b1;
                     tx_valid_d = 1'b1;
                     tx_data_d  = rd_byte;
                     state_d    = ST_RD_SEND;
                  end
                  CMD_STEP: begin
                     step_d     = 1'b1;
                     tx_valid_d = 1'b1;
                     tx_data_d  = ACK_BYTE;
                     state_d    = ST_ACK;
                  end
                  default: begin
                     tx_valid_d = 1'b1;
                     tx_data_d  = NAK_BYTE;
                     state_d    = ST_NAK;
                  end
               endcase
            end
         end

         ST_WR_PAYLOAD: begin
            // An expired counter wins over a byte arriving on the same edge.
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
               idx_d      = '0;
               tmo_d      = '0;
               tx_valid_d = 1'b1;
               tx_data_d  = NAK_BYTE;
               state_d    = ST_NAK;
            end else if (rx_valid) begin
               wr_load = 1'b1;
               tmo_d   = '0;
               if (idx_q == IDX_W'(IN_BYTES - 1)) begin
                  drive_d    = wr_word;
                  idx_d      = '0;
                  tx_valid_d = 1'b1;
                  tx_data_d  = ACK_BYTE;
                  state_d    = ST_ACK;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         ST_RD_SEND: begin
            if (rx_valid) overrun_d = 1'b1;
            if (tx_fire) begin
               tx_valid_d = 1'b0;
               rd_shift   = 1'b1;
               if (idx_q == IDX_W'(OUT_BYTES - 1)) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (!tx_valid_q) begin
               // Guard cycle is over; present the next probe byte.
               tx_valid_d = 1'b1;
               tx_data_d  = rd_byte;
            end
         end

         ST_ACK, ST_NAK: begin
            if (rx_valid) overrun_d = 1'b1;
            if (tx_fire) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCE_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         tmo_q      <= '0;
         drive_q    <= RESET_DRIVE;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         step_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         drive_q    <= drive_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         step_q     <= step_d;
         overrun_q  <= overrun_d;
      end
   end

   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign drive_out = drive_q;
   assign dut_step  = step_q;
   assign busy      = (state_q != ST_IDLE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_debug_bridge.sv
// Randomised bench for uart_debug_bridge with a byte-level host model and a
// UART sink that throttles tx_ready after each transfer.
module tb_uart_debug_bridge;

   localparam int         IW  = 12;
   localparam int         OW  = 20;
   localparam int         TMO = 50;
   localparam logic [11:0] RST_DRIVE = 12'h5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic [11:0] drive_out;
   logic [19:0] probe_in = '0;
   logic        dut_step;
   logic        busy;
   logic        overrun;

   always #5 clk = ~clk;

   uart_debug_bridge #(
      .IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TMO), .RESET_DRIVE(RST_DRIVE)
   ) dut (
      .iCE_CLK   (clk),
      .rst_n     (rst_n),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .drive_out (drive_out),
      .probe_in  (probe_in),
      .dut_step  (dut_step),
      .busy      (busy),
      .overrun   (overrun)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  txq[$];
   int          step_seen = 0;
   int          model_steps = 0;
   logic [11:0] model_drive = RST_DRIVE;
   int          busy_cnt = 0;
   bit          prev_xfer = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // UART sink: records transferred bytes, then stays busy for a random few cycles.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt  = 0;
         tx_ready  = 1'b1;
         prev_xfer = 1'b0;
      end else begin
         if (prev_xfer) check("tx_guard", {63'b0, tx_valid}, 64'd0);
         if (busy_cnt > 0) begin
            tx_ready = 1'b0;
            busy_cnt--;
         end else begin
            tx_ready = 1'b1;
         end
         prev_xfer = tx_valid && tx_ready;
         if (prev_xfer) begin
            txq.push_back(tx_data);
            busy_cnt = $urandom_range(0, 3);
         end
         if (dut_step) step_seen++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_tx(input string tag, input logic [7:0] exp);
      int t = 0;
      while (txq.size() == 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (txq.size() == 0) check({tag, "_missing"}, 64'h100, {56'b0, exp});
      else                 check(tag, {56'b0, txq.pop_front()}, {56'b0, exp});
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while ((busy || tx_valid) && t < 300) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_busy"}, {63'b0, busy}, 64'd0);
   endtask

   task automatic do_write(input logic [15:0] v, input int g0, input int g1, input string tag);
      send_byte(8'h57);
      idle(g0);
      send_byte(v[7:0]);
      idle(g1);
      check({tag, "_pre"}, {52'b0, drive_out}, {52'b0, model_drive});
      send_byte(v[15:8]);
      model_drive = v[11:0];
      check({tag, "_drive"}, {52'b0, drive_out}, {52'b0, model_drive});
      check({tag, "_ack_now"}, {55'b0, tx_valid, tx_data}, {55'b0, 1'b1, 8'h06});
      expect_tx({tag, "_ack"}, 8'h06);
      wait_idle(tag);
   endtask

   task automatic do_write_timeout(input logic [7:0] b0, input int g0, input string tag);
      send_byte(8'h57);
      idle(g0);
      send_byte(b0);
      idle(TMO);
      check({tag, "_still_wait"}, {63'b0, tx_valid}, 64'd0);
      idle(1);
      check({tag, "_nak_now"}, {55'b0, tx_valid, tx_data}, {55'b0, 1'b1, 8'h15});
      expect_tx({tag, "_nak"}, 8'h15);
      wait_idle(tag);
      check({tag, "_drive"}, {52'b0, drive_out}, {52'b0, model_drive});
   endtask

   task automatic do_read(input logic [19:0] p, input string tag);
      probe_in = p;
      send_byte(8'h52);
      probe_in = 20'($urandom);
      for (int k = 0; k < 3; k++) expect_tx($sformatf("%s_b%0d", tag, k), 8'(p >> (8 * k)));
      wait_idle(tag);
   endtask

   task automatic do_step(input string tag);
      model_steps++;
      send_byte(8'h53);
      check({tag, "_hi"}, {63'b0, dut_step}, 64'd1);
      @(negedge clk);
      check({tag, "_lo"}, {63'b0, dut_step}, 64'd0);
      expect_tx({tag, "_ack"}, 8'h06);
      wait_idle(tag);
   endtask

   task automatic do_bad(input logic [7:0] b, input string tag);
      send_byte(b);
      expect_tx({tag, "_nak"}, 8'h15);
      wait_idle(tag);
      check({tag, "_drive"}, {52'b0, drive_out}, {52'b0, model_drive});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  b;
      logic [15:0] v;
      idle(3);
      check("rst_drive", {52'b0, drive_out}, {52'b0, RST_DRIVE});
      check("rst_tx", {55'b0, tx_valid, tx_data}, 64'd0);
      check("rst_flags", {61'b0, dut_step, busy, overrun}, 64'd0);
      rst_n = 1'b1;
      idle(2);

      do_write(16'hF234, 0, 0, "wr_234");
      do_read(20'hABCDE, "rd_abcde");
      do_bad(8'h41, "bad_41");
      do_write_timeout(8'h34, 0, "tmo_dir");
      do_write(16'h0001, 0, 0, "wr_001");
      do_write(16'h0F12, 49, 49, "wr_gap49");
      do_write(16'h5752, 3, 0, "wr_cmdpayload");

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0: begin
               v = 16'($urandom);
               do_write(v, $urandom_range(0, 49), $urandom_range(0, 49), $sformatf("rnd%0d_wr", i));
            end
            1: do_write_timeout(8'($urandom), $urandom_range(0, 10), $sformatf("rnd%0d_tmo", i));
            2: do_read(20'($urandom), $sformatf("rnd%0d_rd", i));
            3: do_step($sformatf("rnd%0d_step", i));
            default: begin
               do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h53);
               do_bad(b, $sformatf("rnd%0d_bad", i));
            end
         endcase
      end

      check("ovr_before", {63'b0, overrun}, 64'd0);
      model_steps++;
      send_byte(8'h53);
      send_byte(8'h41);
      expect_tx("ovr_ack", 8'h06);
      wait_idle("ovr");
      idle(5);
      check("ovr_noresp", txq.size(), 64'd0);
      check("ovr_set", {63'b0, overrun}, 64'd1);
      do_read(20'h13579, "ovr_rd");
      check("ovr_sticky", {63'b0, overrun}, 64'd1);
      check("step_count", step_seen, model_steps);

      send_byte(8'h57);
      send_byte(8'h34);
      idle(2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_drive", {52'b0, drive_out}, {52'b0, RST_DRIVE});
      check("mid_rst_flags", {61'b0, tx_valid, busy, overrun}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_drive = RST_DRIVE;
      txq.delete();
      idle(2);
      check("post_rst_noresp", txq.size(), 64'd0);
      do_write(16'h0ABC, 1, 2, "wr_after_rst");
      check("post_rst_ovr", {63'b0, overrun}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_debug_bridge.md
# uart_debug_bridge

Parametrised command engine between the UART byte stream and the design under debug. It decodes host commands from received bytes, drives an IN_WIDTH-bit stimulus vector into the DUT, snapshots an OUT_WIDTH-bit probe vector back to the host, and issues single-cycle DUT step pulses. It replaces the fixed 8-bit echo loop in the top level. The existing `uart` instance stays in the top level and connects to this block's rx/tx byte ports.

## Interface
- IN_WIDTH, 8: stimulus width, 1..64.
- OUT_WIDTH, 8: probe width, 1..64.
- TIMEOUT_CYCLES, 120000: maximum idle clocks between payload bytes before a write is aborted (≥2).
- RESET_DRIVE, 0: value of drive_out in reset.

- iCE_CLK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte (from uart `received`).
- rx_data  in  8  received byte.
- tx_valid  out  1  byte offered for transmission.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  transmitter idle (`!is_transmitting`).
- drive_out  out  IN_WIDTH  stimulus to DUT.
- probe_in  in  OUT_WIDTH  DUT observation.
- dut_step  out  1  one-cycle step pulse.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky: a byte arrived while a response was pending.

## Operation
- IN_BYTES = ceil(IN_WIDTH/8); OUT_BYTES = ceil(OUT_WIDTH/8). Multi-byte values are sent LSB byte first.
- Commands:
  - 0x57 'W' plus IN_BYTES payload bytes: assemble the payload, commit atomically to drive_out, reply ACK 0x06. Bits above IN_WIDTH in the last byte are ignored.
  - 0x52 'R': snapshot probe_in and send OUT_BYTES bytes, zero-padded above OUT_WIDTH.
  - 0x53 'S': pulse dut_step, reply ACK.
  - Any other byte: reply NAK 0x15.
- States and transitions:
  - IDLE → WR_PAYLOAD on 'W'.
  - IDLE → RD_SEND on 'R'.
  - IDLE → ACK on 'S'.
  - IDLE → NAK on an unknown byte.
  - WR_PAYLOAD → ACK after the last payload byte.
  - WR_PAYLOAD → NAK on timeout.
  - RD_SEND, ACK, NAK → IDLE once the final byte has transferred.
- Timeout counter: reset on entry to WR_PAYLOAD and on each payload byte. When it reaches TIMEOUT_CYCLES, the partial payload is discarded and drive_out is unchanged.
- rx_valid in RD_SEND, ACK or NAK: the byte is dropped and overrun is set. overrun clears only on reset.
- Payload bytes in WR_PAYLOAD are never treated as commands, including 0x57, 0x52 and 0x53.

## Timing
- Reset values: drive_out=RESET_DRIVE; tx_valid=0; tx_data=0; dut_step=0; busy=0; overrun=0; state=IDLE; counters 0.
- Reset asserted mid-operation aborts immediately: no further tx, drive_out returns to RESET_DRIVE.
- Byte transfer rule: a byte transfers on an edge where tx_valid && tx_ready. tx_valid deasserts on the following cycle (guard cycle, so the UART busy flag can rise), then reasserts for the next byte. tx_data is stable while tx_valid is high.
- Write: last payload byte accepted at edge N → drive_out updated at N+1, and tx_valid=1 with tx_data=0x06 from N+1.
- Read: 'R' accepted at edge N → probe_in sampled at edge N; byte 0 offered from N+1.
- Step: 'S' accepted at edge N → dut_step high for exactly cycle N+1 to N+2; ACK offered from N+1.
- NAK after timeout: offered on the cycle after the counter hits TIMEOUT_CYCLES.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1).

## Structure
- Package `dbg_bridge_pkg`:
  - command codes 0x57, 0x52, 0x53;
  - ACK and NAK codes;
  - state enum.
- Sub-module `dbg_byte_shifter`: parametrised width. Loads a byte at a byte index (write assembly) and shifts out byte-by-byte (read serialisation). It is instantiated twice.
- Byte index counters are $clog2(max(IN_BYTES, OUT_BYTES)+1) bits wide.

## Test plan
(All scenarios: IN_WIDTH=12, OUT_WIDTH=20, TIMEOUT_CYCLES=50.)
- rx 0x57, 0x34, 0xF2 → drive_out=0x234 one cycle after 0xF2; tx 0x06.
- probe_in=0xABCDE, rx 0x52 → tx 0xDE, 0xBC, 0x0A in order. probe_in changes after the command do not alter the reply.
- rx 0x41 → tx 0x15; drive_out unchanged; busy returns to 0.
- rx 0x57, 0x34, then 51 idle cycles → tx 0x15, drive_out unchanged. A following 0x57, 0x01, 0x00 → drive_out=0x001.
- rx 0x53 → dut_step high exactly one cycle, tx 0x06. An rx byte during that reply → dropped, overrun=1 until rst_n.
- rst_n low after 0x57, 0x34 → drive_out=RESET_DRIVE, tx_valid=0, busy=0. A subsequent write completes normally.
